// File: rtl/alu_pkg.sv
// Shared definitions for seq_alu and its iterative multiply/divide datapath.
//   - opcode encodings OP_ADD .. OP_SDIV (0x14..0x1F are illegal)
//   - execute-stage FSM state type
//   - bit positions of the {Z,N,C,V} condition-code register
package alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'h00;
  localparam logic [4:0] OP_ADDX  = 5'h01;
  localparam logic [4:0] OP_SUB   = 5'h02;
  localparam logic [4:0] OP_SUBX  = 5'h03;
  localparam logic [4:0] OP_AND   = 5'h04;
  localparam logic [4:0] OP_OR    = 5'h05;
  localparam logic [4:0] OP_XOR   = 5'h06;
  localparam logic [4:0] OP_XNOR  = 5'h07;
  localparam logic [4:0] OP_ANDN  = 5'h08;
  localparam logic [4:0] OP_ORN   = 5'h09;
  localparam logic [4:0] OP_SLL   = 5'h0A;
  localparam logic [4:0] OP_SRL   = 5'h0B;
  localparam logic [4:0] OP_SRA   = 5'h0C;
  localparam logic [4:0] OP_PASSA = 5'h0D;
  localparam logic [4:0] OP_PASSB = 5'h0E;
  localparam logic [4:0] OP_NOTB  = 5'h0F;
  localparam logic [4:0] OP_UMUL  = 5'h10;
  localparam logic [4:0] OP_SMUL  = 5'h11;
  localparam logic [4:0] OP_UDIV  = 5'h12;
  localparam logic [4:0] OP_SDIV  = 5'h13;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam int unsigned ICC_Z = 3;
  localparam int unsigned ICC_N = 2;
  localparam int unsigned ICC_C = 1;
  localparam int unsigned ICC_V = 0;

  // 0x10..0x13: the low two bits then select {div, signed}.
  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4:2] == 3'b100;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply / restoring divide datapath, one step per clock.
//   clk, rst   clock, asynchronous active-high reset
//   start      load operands and begin WIDTH iterations
//   op         {div, signed}: 00 UMUL, 01 SMUL, 10 UDIV, 11 SDIV
//   a, b       operands (multiplicand/multiplier or dividend/divisor)
//   done       high during the last iteration; lo/hi are then the final result
//   lo, hi     product low/high word, or quotient/remainder (sign-corrected)
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             run_q, run_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // product high word / partial remainder
  logic [WIDTH-1:0] sr_q, sr_d;       // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor magnitude
  logic             div_q, div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   acc_it, sr_it;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic               sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;

  always_comb begin
    sgn   = op[0];
    mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    mag_b = (sgn && b[WIDTH-1]) ? -b : b;

    mul_sum = {1'b0, acc_q} + (sr_q[0] ? {1'b0, opnd_q} : '0);
    div_sh  = {acc_q, sr_q[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, opnd_q};
    if (div_q) begin
      // When div_sh >= divisor the difference is below the divisor, so it fits WIDTH bits.
      acc_it = div_ge ? (div_sh[WIDTH-1:0] - opnd_q) : div_sh[WIDTH-1:0];
      sr_it  = {sr_q[WIDTH-2:0], div_ge};
    end else begin
      acc_it = mul_sum[WIDTH:1];
      sr_it  = {mul_sum[0], sr_q[WIDTH-1:1]};
    end

    run_d    = run_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sr_d     = sr_q;
    opnd_d   = opnd_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    if (start) begin
      run_d    = 1'b1;
      cnt_d    = CW'(WIDTH - 1);
      acc_d    = '0;
      sr_d     = mag_a;
      opnd_d   = mag_b;
      div_d    = op[1];
      neg_lo_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi_d = sgn && op[1] && a[WIDTH-1];
    end else if (run_q) begin
      acc_d = acc_it;
      sr_d  = sr_it;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      sr_q     <= '0;
      opnd_q   <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sr_q     <= sr_d;
      opnd_q   <= opnd_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

  // Final result is taken from this cycle's iteration so it lands at the edge entering DONE.
  always_comb begin
    prod   = {acc_it, sr_it};
    prod_s = neg_lo_q ? -prod : prod;
    if (div_q) begin
      lo = neg_lo_q ? -sr_it : sr_it;
      hi = neg_hi_q ? -acc_it : acc_it;
    end else begin
      lo = prod_s[WIDTH-1:0];
      hi = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/seq_alu.sv
// Execute-stage ALU: one-cycle logic/arith/shift ops plus iterative mul/div.
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready request handshake (ready is low only while iterating)
//   opcode, a, b, cin operation and operands, latched at acceptance
//   set_cc            write icc when the accepted op completes
//   out_valid         one-cycle result strobe
//   y, y_hi           result / product high word or remainder (held until next completion)
//   icc               registered {Z,N,C,V}
//   div_zero          divisor was zero (qualified by out_valid)
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             set_cc,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic [3:0]       icc,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d, y_hi_q, y_hi_d;
  logic [3:0]       icc_q, icc_d;
  logic             div_zero_q, div_zero_d;
  logic             set_cc_q, set_cc_d;
  logic             ovf_q, ovf_d;     // SDIV of most-negative by -1

  logic             accept, md_start, md_done;
  logic [WIDTH-1:0] md_lo, md_hi, fin_y;
  logic [WIDTH:0]   add_sum, sub_diff;
  logic [WIDTH-1:0] res_y, res_hi;
  logic             res_c, res_v, res_dz, res_legal;

  assign in_ready  = (state_q != StBusy);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;
  assign md_start  = accept && is_muldiv(opcode) && !(opcode[1] && (b == '0));

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk  (clk),
    .rst  (rst),
    .start(md_start),
    .op   (opcode[1:0]),
    .a    (a),
    .b    (b),
    .done (md_done),
    .lo   (md_lo),
    .hi   (md_hi)
  );

  // One-cycle ops, evaluated on the inputs present at acceptance.
  always_comb begin
    add_sum   = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin && (opcode == OP_ADDX));
    sub_diff  = {1'b0, a} - {1'b0, b} - (WIDTH + 1)'(cin && (opcode == OP_SUBX));
    res_y     = '0;
    res_hi    = '0;
    res_c     = 1'b0;
    res_v     = 1'b0;
    res_dz    = 1'b0;
    res_legal = 1'b1;
    case (opcode)
      OP_ADD, OP_ADDX: begin
        res_y = add_sum[WIDTH-1:0];
        res_c = add_sum[WIDTH];
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SUBX: begin
        res_y = sub_diff[WIDTH-1:0];
        res_c = sub_diff[WIDTH];
        res_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   res_y = a & b;
      OP_OR:    res_y = a | b;
      OP_XOR:   res_y = a ^ b;
      OP_XNOR:  res_y = ~(a ^ b);
      OP_ANDN:  res_y = a & ~b;
      OP_ORN:   res_y = a | ~b;
      OP_SLL:   res_y = a << b[SHW-1:0];
      OP_SRL:   res_y = a >> b[SHW-1:0];
      OP_SRA:   res_y = $signed(a) >>> b[SHW-1:0];
      OP_PASSA: res_y = a;
      OP_PASSB: res_y = b;
      OP_NOTB:  res_y = ~b;
      OP_UMUL, OP_SMUL: ;
      OP_UDIV, OP_SDIV: begin
        // Only reached here with a zero divisor; otherwise the iterator takes over.
        res_y  = '1;
        res_hi = a;
        res_dz = 1'b1;
        res_v  = 1'b1;
      end
      default: res_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    y_hi_d     = y_hi_q;
    icc_d      = icc_q;
    div_zero_d = div_zero_q;
    set_cc_d   = set_cc_q;
    ovf_d      = ovf_q;
    fin_y      = ovf_q ? MaxPos : md_lo;
    unique case (state_q)
      StIdle, StDone: begin
        if (md_start) begin
          state_d  = StBusy;
          set_cc_d = set_cc;
          ovf_d    = (opcode == OP_SDIV) && (a == MinNeg) && (b == '1);
        end else if (accept) begin
          state_d    = StDone;
          y_d        = res_y;
          y_hi_d     = res_hi;
          div_zero_d = res_dz;
          if (set_cc && res_legal) begin
            icc_d[ICC_Z] = (res_y == '0);
            icc_d[ICC_N] = res_y[WIDTH-1];
            icc_d[ICC_C] = res_c;
            icc_d[ICC_V] = res_v;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        if (md_done) begin
          state_d    = StDone;
          y_d        = fin_y;
          y_hi_d     = md_hi;
          div_zero_d = 1'b0;
          if (set_cc_q) begin
            icc_d[ICC_Z] = (fin_y == '0);
            icc_d[ICC_N] = fin_y[WIDTH-1];
            icc_d[ICC_C] = 1'b0;
            icc_d[ICC_V] = ovf_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      y_q        <= '0;
      y_hi_q     <= '0;
      icc_q      <= '0;
      div_zero_q <= 1'b0;
      set_cc_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      y_hi_q     <= y_hi_d;
      icc_q      <= icc_d;
      div_zero_q <= div_zero_d;
      set_cc_q   <= set_cc_d;
      ovf_q      <= ovf_d;
    end
  end

  assign y        = y_q;
  assign y_hi     = y_hi_q;
  assign icc      = icc_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, set_cc, out_valid, div_zero;
  logic [4:0]  opcode;
  logic [31:0] a, b, y, y_hi;
  logic [3:0]  icc;

  logic        in_valid8, in_ready8, cin8, set_cc8, out_valid8, div_zero8;
  logic [4:0]  opcode8;
  logic [7:0]  a8, b8, y8, y_hi8;
  logic [3:0]  icc8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .a(a), .b(b), .cin(cin), .set_cc(set_cc), .out_valid(out_valid), .y(y),
    .y_hi(y_hi), .icc(icc), .div_zero(div_zero)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .opcode(opcode8),
    .a(a8), .b(b8), .cin(cin8), .set_cc(set_cc8), .out_valid(out_valid8), .y(y8),
    .y_hi(y_hi8), .icc(icc8), .div_zero(div_zero8)
  );

  // Present one request for exactly one edge; returns #1 after that edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ic, input logic sc);
    opcode = op; a = ia; b = ib; cin = ic; set_cc = sc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [4:0] op, input logic [7:0] ia, input logic [7:0] ib);
    opcode8 = op; a8 = ia; b8 = ib; set_cc8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  // Called in the first cycle after acceptance; cyc = cycle index at which out_valid seen.
  task automatic wait_out(input bit w8, output int cyc, output int low);
    cyc = 1;
    low = 0;
    while (!(w8 ? out_valid8 : out_valid) && cyc < 200) begin
      if (!(w8 ? in_ready8 : in_ready)) low++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_valid8 = 1'b0; cin8 = 1'b0;
    opcode = '0; a = '0; b = '0; cin = 1'b0; set_cc = 1'b0;
    opcode8 = '0; a8 = '0; b8 = '0; set_cc8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, y, y_hi, icc, div_zero} !== {1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset32: rdy=%b ov=%b y=%h hi=%h icc=%b dz=%b, expected 1 0 0 0 0000 0",
               in_ready, out_valid, y, y_hi, icc, div_zero);
    end
    n_checks++;
    if ({in_ready8, out_valid8, y8, y_hi8, icc8, div_zero8} !== {1'b1, 1'b0, 8'h0, 8'h0, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset8: rdy=%b ov=%b y=%h hi=%h icc=%b dz=%b, expected 1 0 0 0 0000 0",
               in_ready8, out_valid8, y8, y_hi8, icc8, div_zero8);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_flags;
    issue(5'h00, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
    n_checks++;
    if ({out_valid, y, y_hi, icc} !== {1'b1, 32'h8000_0000, 32'h0, 4'b0101}) begin
      n_fail++;
      $display("FAIL add_ovf: ov=%b y=%h hi=%h icc=%b, expected 1 80000000 0 0101", out_valid, y, y_hi, icc);
    end
    issue(5'h00, 32'h0, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if ({y, icc} !== {32'h0, 4'b0101}) begin
      n_fail++;
      $display("FAIL add_nocc: y=%h icc=%b, expected 00000000 0101", y, icc);
    end
    issue(5'h00, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    n_checks++;
    if ({y, icc} !== {32'h8000_0000, 4'b0101}) begin
      n_fail++;
      $display("FAIL add_nocc2: y=%h icc=%b, expected 80000000 0101", y, icc);
    end
    issue(5'h01, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    n_checks++;
    if ({y, icc} !== {32'h0, 4'b1010}) begin
      n_fail++;
      $display("FAIL addx_carry: y=%h icc=%b, expected 00000000 1010", y, icc);
    end
  endtask

  task automatic test_back_to_back;
    issue(5'h03, 32'h0, 32'h0, 1'b1, 1'b1);
    n_checks++;
    if ({out_valid, in_ready, y, icc} !== {1'b1, 1'b1, 32'hFFFF_FFFF, 4'b0110}) begin
      n_fail++;
      $display("FAIL subx: ov=%b rdy=%b y=%h icc=%b, expected 1 1 ffffffff 0110", out_valid, in_ready, y, icc);
    end
    issue(5'h06, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0, 1'b1);
    n_checks++;
    if ({out_valid, y, icc} !== {1'b1, 32'h0, 4'b1000}) begin
      n_fail++;
      $display("FAIL b2b_xor: ov=%b y=%h icc=%b, expected 1 00000000 1000", out_valid, y, icc);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ov_drop: ov=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_logic;
    logic [4:0]  ops [13];
    logic [31:0] exp [13];
    ops = '{5'h02, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C,
            5'h0D, 5'h0E, 5'h0F};
    exp = '{32'hE100_1230, 32'h00F0_0004, 32'hFFF0_1234, 32'hFF00_1230, 32'h00FF_EDCF,
            32'hF000_1230, 32'hF0FF_FFFF, 32'h0F01_2340, 32'h0F0F_0123, 32'hFF0F_0123,
            32'hF0F0_1234, 32'h0FF0_0004, 32'hF00F_FFFB};
    for (int i = 0; i < 13; i++) begin
      issue(ops[i], 32'hF0F0_1234, 32'h0FF0_0004, 1'b1, 1'b0);
      n_checks++;
      if ({out_valid, y, y_hi} !== {1'b1, exp[i], 32'h0}) begin
        n_fail++;
        $display("FAIL logic_op%h: ov=%b y=%h hi=%h, expected 1 %h 0", ops[i], out_valid, y, y_hi, exp[i]);
      end
    end
    issue(5'h05, 32'hF0F0_1234, 32'h0FF0_0004, 1'b0, 1'b1);
    n_checks++;
    if (icc !== 4'b0100) begin
      n_fail++;
      $display("FAIL or_cc: icc=%b, expected 0100", icc);
    end
    issue(5'h15, 32'hF0F0_1234, 32'h0FF0_0004, 1'b0, 1'b1);
    n_checks++;
    if ({out_valid, y, y_hi, icc, div_zero} !== {1'b1, 32'h0, 32'h0, 4'b0100, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal: ov=%b y=%h hi=%h icc=%b dz=%b, expected 1 0 0 0100 0",
               out_valid, y, y_hi, icc, div_zero);
    end
  endtask

  task automatic test_smul;
    int cyc, low;
    issue(5'h11, 32'hFFFF_FFFD, 32'h7, 1'b0, 1'b1);
    // Operands changing mid-operation must not disturb the result.
    opcode = 5'h05; a = 32'h1234_5678; b = 32'h9ABC_DEF0; set_cc = 1'b0;
    wait_out(1'b0, cyc, low);
    n_checks++;
    if (cyc != 33 || low != 32) begin
      n_fail++;
      $display("FAIL smul_timing: out_valid at %0d busy %0d, expected 33 and 32", cyc, low);
    end
    n_checks++;
    if ({y_hi, y, icc} !== {64'hFFFF_FFFF_FFFF_FFEB, 4'b0100}) begin
      n_fail++;
      $display("FAIL smul: got %h_%h icc=%b, expected ffffffff_ffffffeb 0100", y_hi, y, icc);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, y} !== {1'b0, 32'hFFFF_FFEB}) begin
      n_fail++;
      $display("FAIL smul_hold: ov=%b y=%h, expected 0 ffffffeb", out_valid, y);
    end
  endtask

  task automatic test_div;
    int cyc, low;
    issue(5'h13, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_out(1'b0, cyc, low);
    n_checks++;
    if ({y, y_hi, icc, div_zero} !== {32'h7FFF_FFFF, 32'h0, 4'b0001, 1'b0} || cyc != 33) begin
      n_fail++;
      $display("FAIL sdiv_ovf: y=%h hi=%h icc=%b dz=%b at %0d, expected 7fffffff 0 0001 0 at 33",
               y, y_hi, icc, div_zero, cyc);
    end
    issue(5'h12, 32'd100, 32'd7, 1'b0, 1'b0);
    wait_out(1'b0, cyc, low);
    n_checks++;
    if ({y, y_hi, icc} !== {32'd14, 32'd2, 4'b0001}) begin
      n_fail++;
      $display("FAIL udiv: y=%h hi=%h icc=%b, expected 0000000e 00000002 0001", y, y_hi, icc);
    end
    issue(5'h13, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    wait_out(1'b0, cyc, low);
    n_checks++;
    if ({y, y_hi, icc} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b0100}) begin
      n_fail++;
      $display("FAIL sdiv_neg: y=%h hi=%h icc=%b, expected fffffffd ffffffff 0100", y, y_hi, icc);
    end
    issue(5'h12, 32'd100, 32'd0, 1'b0, 1'b1);
    n_checks++;
    if ({out_valid, in_ready, y, y_hi, div_zero, icc} !==
        {1'b1, 1'b1, 32'hFFFF_FFFF, 32'd100, 1'b1, 4'b0101}) begin
      n_fail++;
      $display("FAIL udiv_zero: ov=%b rdy=%b y=%h hi=%h dz=%b icc=%b, expected 1 1 ffffffff 64 1 0101",
               out_valid, in_ready, y, y_hi, div_zero, icc);
    end
  endtask

  task automatic test_width8;
    int cyc, low;
    issue8(5'h0C, 8'h80, 8'h03);
    n_checks++;
    if ({out_valid8, y8} !== {1'b1, 8'hF0}) begin
      n_fail++;
      $display("FAIL sra8: ov=%b y=%h, expected 1 f0", out_valid8, y8);
    end
    issue8(5'h10, 8'hFF, 8'hFF);
    wait_out(1'b1, cyc, low);
    n_checks++;
    if ({y_hi8, y8} !== 16'hFE01 || cyc != 9 || low != 8) begin
      n_fail++;
      $display("FAIL umul8: got %h_%h at %0d busy %0d, expected fe_01 at 9 busy 8", y_hi8, y8, cyc, low);
    end
  endtask

  task automatic test_reset_mid_op;
    int seen;
    issue(5'h10, 32'd5, 32'd6, 1'b0, 1'b1);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, y, y_hi, icc, div_zero} !== {1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid: rdy=%b ov=%b y=%h hi=%h icc=%b dz=%b, expected 1 0 0 0 0000 0",
               in_ready, out_valid, y, y_hi, icc, div_zero);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_no_ov: out_valid seen %0d times, expected 0", seen);
    end
    issue(5'h00, 32'd2, 32'd3, 1'b0, 1'b1);
    n_checks++;
    if ({out_valid, y, icc} !== {1'b1, 32'd5, 4'b0000}) begin
      n_fail++;
      $display("FAIL add_after_rst: ov=%b y=%h icc=%b, expected 1 00000005 0000", out_valid, y, icc);
    end
  endtask

  initial begin
    test_reset();
    test_add_flags();
    test_back_to_back();
    test_logic();
    test_smul();
    test_div();
    test_width8();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
